iir_biquad_coeff_ctrl: RTL and testbench

// - Coefficient configuration controller for the 3-section (6th-order) biquad cascade.
// - Host writes a1/a2/k per section into a shadow bank; the whole bank commits atomically to the

---
 rtl/iir_cfg_pkg.sv | 32 +++
 rtl/iir_inflight_counter.sv | 37 +++
 rtl/iir_biquad_coeff_ctrl.sv | 131 +++++++++++++
 tb/tb_iir_biquad_coeff_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cfg_pkg.sv
// Shared types and constants for the biquad coefficient configuration controller.
// COEF_W must match the controller's DATA_WIDTH_P.
package iir_cfg_pkg;

  localparam int unsigned COEF_W = 24;

  localparam logic [1:0] COEF_A1 = 2'd0;
  localparam logic [1:0] COEF_A2 = 2'd1;
  localparam logic [1:0] COEF_K  = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    COMMIT
  } cfg_state_t;

  typedef struct packed {
    logic [COEF_W-1:0] a1;
    logic [COEF_W-1:0] a2;
    logic [COEF_W-1:0] k;
  } biquad_coef_t;

  // Zero feedback with unity gain: the section passes samples through untouched.
  function automatic biquad_coef_t pass_through_coef(input int unsigned q_bits);
    biquad_coef_t c;
    c    = '0;
    c.k  = COEF_W'(1) << q_bits;
    return c;
  endfunction

endpackage

// File: rtl/iir_inflight_counter.sv
// Counts samples held inside the biquad cascade: +1 on entry, -1 on exit, saturating.
// A decrement at zero is dropped and reported on underflow for one cycle.
module iir_inflight_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         underflow
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec) begin
      if (count_q != '1) count_d = count_q + W'(1);
    end else if (dec && !inc) begin
      if (count_q == '0) underflow = 1'b1;
      else               count_d   = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/iir_biquad_coeff_ctrl.sv
// Shadow/live coefficient bank for a biquad cascade with drain-then-commit update.
// Optional macro IIR_CFG_DRAIN_TIMEOUT_EN bounds the drain wait to DRAIN_TIMEOUT_P cycles.
module iir_biquad_coeff_ctrl
  import iir_cfg_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_P     = 24,
  parameter int unsigned NR_OF_Q_BITS_P   = 20,
  parameter int unsigned NR_OF_SECTIONS_P = 3,
  parameter int unsigned INFLIGHT_W_P     = 8,
  parameter int unsigned DRAIN_TIMEOUT_P  = 1024
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            cfg_valid,
  output logic                                            cfg_ready,
  input  logic [$clog2(NR_OF_SECTIONS_P)-1:0]             cfg_section,
  input  logic [1:0]                                      cfg_index,
  input  logic [DATA_WIDTH_P-1:0]                         cfg_data,
  input  logic                                            cfg_last,
  output logic                                            cfg_commit_done,
  output logic                                            cfg_error,
  input  logic                                            x_valid_in,
  input  logic [DATA_WIDTH_P-1:0]                         x_in,
  output logic                                            x_ready,
  output logic                                            x_valid_out,
  output logic [DATA_WIDTH_P-1:0]                         x_out,
  input  logic                                            y_valid_in,
  output logic [NR_OF_SECTIONS_P-1:0][DATA_WIDTH_P-1:0]   cr_a1,
  output logic [NR_OF_SECTIONS_P-1:0][DATA_WIDTH_P-1:0]   cr_a2,
  output logic [NR_OF_SECTIONS_P-1:0][DATA_WIDTH_P-1:0]   cr_gain_k
);

  localparam biquad_coef_t PASS_COEF = pass_through_coef(NR_OF_Q_BITS_P);

  cfg_state_t state_q, state_d;
  biquad_coef_t [NR_OF_SECTIONS_P-1:0] shadow_q, shadow_d, live_q;

  logic                    cfg_fire;
  logic                    cfg_illegal;
  logic [INFLIGHT_W_P-1:0] inflight;
  logic                    underflow;
  logic                    drain_timeout;
  logic                    error_q;

  assign cfg_ready       = (state_q == IDLE) || (state_q == LOAD);
  assign x_ready         = cfg_ready;
  assign x_valid_out     = x_valid_in & x_ready;
  assign x_out           = x_in;
  assign cfg_commit_done = (state_q == COMMIT);
  assign cfg_error       = error_q;

  assign cfg_fire    = cfg_valid & cfg_ready;
  assign cfg_illegal = cfg_fire &&
                       ((cfg_index == 2'd3) || (32'(cfg_section) >= NR_OF_SECTIONS_P));

  iir_inflight_counter #(
    .W (INFLIGHT_W_P)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .inc       (x_valid_out),
    .dec       (y_valid_in),
    .clr       (drain_timeout),
    .count     (inflight),
    .underflow (underflow)
  );

`ifdef IIR_CFG_DRAIN_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(DRAIN_TIMEOUT_P);

  logic [TO_W-1:0] drain_cnt_q;

  // Counter value equals the number of DRAIN cycles already spent.
  assign drain_timeout = (state_q == DRAIN) && (inflight != '0) &&
                         (drain_cnt_q == TO_W'(DRAIN_TIMEOUT_P - 1));

  always_ff @(posedge clk) begin
    if (rst || (state_q != DRAIN)) drain_cnt_q <= '0;
    else if (!drain_timeout)       drain_cnt_q <= drain_cnt_q + TO_W'(1);
  end
`else
  logic unused_drain_timeout;
  assign unused_drain_timeout = ^DRAIN_TIMEOUT_P;
  assign drain_timeout        = 1'b0;
`endif

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_fire && !cfg_illegal) begin
      case (cfg_index)
        COEF_A1: shadow_d[cfg_section].a1 = COEF_W'(cfg_data);
        COEF_A2: shadow_d[cfg_section].a2 = COEF_W'(cfg_data);
        COEF_K:  shadow_d[cfg_section].k  = COEF_W'(cfg_data);
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_fire) state_d = cfg_last ? DRAIN : LOAD;
      LOAD:    if (cfg_fire && cfg_last) state_d = DRAIN;
      DRAIN:   if ((inflight == '0) || drain_timeout) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Live bank loads on the edge into COMMIT so cfg_commit_done coincides with new values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= {NR_OF_SECTIONS_P{PASS_COEF}};
      live_q   <= {NR_OF_SECTIONS_P{PASS_COEF}};
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      if ((state_q == DRAIN) && (state_d == COMMIT)) live_q <= shadow_q;
      error_q  <= error_q | cfg_illegal | underflow | drain_timeout;
    end
  end

  for (genvar s = 0; s < NR_OF_SECTIONS_P; s++) begin : g_cr
    assign cr_a1[s]     = DATA_WIDTH_P'(live_q[s].a1);
    assign cr_a2[s]     = DATA_WIDTH_P'(live_q[s].a2);
    assign cr_gain_k[s] = DATA_WIDTH_P'(live_q[s].k);
  end

endmodule

// File: tb/tb_iir_biquad_coeff_ctrl.sv
// Directed, table-driven bench for iir_biquad_coeff_ctrl; the timeout sequence runs only
// when IIR_CFG_DRAIN_TIMEOUT_EN is defined.
module tb_iir_biquad_coeff_ctrl;

  localparam logic [23:0] UNITY = 24'h100000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [1:0]        cfg_section = '0;
  logic [1:0]        cfg_index = '0;
  logic [23:0]       cfg_data = '0;
  logic              cfg_last = 1'b0;
  logic              cfg_commit_done;
  logic              cfg_error;
  logic              x_valid_in = 1'b0;
  logic [23:0]       x_in = '0;
  logic              x_ready;
  logic              x_valid_out;
  logic [23:0]       x_out;
  logic              y_valid_in = 1'b0;
  logic [2:0][23:0]  cr_a1, cr_a2, cr_gain_k;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iir_biquad_coeff_ctrl #(
    .DATA_WIDTH_P     (24),
    .NR_OF_Q_BITS_P   (20),
    .NR_OF_SECTIONS_P (3),
    .INFLIGHT_W_P     (8),
    .DRAIN_TIMEOUT_P  (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg_section     (cfg_section),
    .cfg_index       (cfg_index),
    .cfg_data        (cfg_data),
    .cfg_last        (cfg_last),
    .cfg_commit_done (cfg_commit_done),
    .cfg_error       (cfg_error),
    .x_valid_in      (x_valid_in),
    .x_in            (x_in),
    .x_ready         (x_ready),
    .x_valid_out     (x_valid_out),
    .x_out           (x_out),
    .y_valid_in      (y_valid_in),
    .cr_a1           (cr_a1),
    .cr_a2           (cr_a2),
    .cr_gain_k       (cr_gain_k)
  );

  typedef struct {
    int          sec;
    int          idx;
    logic [23:0] data;
    int          chk_sec;
    int          chk_idx;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // All stimulus is driven and all outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] coef(input int s, input int idx);
    case (idx)
      0:       return cr_a1[s];
      1:       return cr_a2[s];
      default: return cr_gain_k[s];
    endcase
  endfunction

  task automatic do_reset();
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_last   = 1'b0;
    x_valid_in = 1'b0;
    y_valid_in = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int sec, input int idx, input logic [23:0] data,
                           input logic last);
    cfg_valid   = 1'b1;
    cfg_section = 2'(sec);
    cfg_index   = 2'(idx);
    cfg_data    = data;
    cfg_last    = last;
    tick();
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
  endtask

  // Called in the cycle after the write was accepted (cycle 1); returns the cycle of the pulse.
  task automatic wait_commit(output int n);
    n = 1;
    while (!cfg_commit_done && n < 64) begin
      tick();
      n++;
    end
    check("commit_seen", 32'(cfg_commit_done), 32'd1);
  endtask

  initial begin
    int n;

    vecs[0] = '{1, 0, 24'h012345, 1, 0, 24'h012345};
    vecs[1] = '{0, 1, 24'hFFF000, 0, 1, 24'hFFF000};
    vecs[2] = '{2, 2, 24'h080000, 2, 2, 24'h080000};
    vecs[3] = '{1, 2, 24'h7FFFFF, 1, 2, 24'h7FFFFF};
    vecs[4] = '{0, 0, 24'h000001, 1, 0, 24'h012345};
    vecs[5] = '{2, 0, 24'h800000, 0, 2, UNITY};

    do_reset();

    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst_a1_s%0d", s), 32'(cr_a1[s]), 32'd0);
      check($sformatf("rst_a2_s%0d", s), 32'(cr_a2[s]), 32'd0);
      check($sformatf("rst_k_s%0d", s), 32'(cr_gain_k[s]), 32'(UNITY));
    end
    check("rst_x_ready", 32'(x_ready), 32'd1);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_commit_done", 32'(cfg_commit_done), 32'd0);
    check("rst_error", 32'(cfg_error), 32'd0);

    // Single-write banks with an idle cascade.
    for (int i = 0; i < 6; i++) begin
      cfg_write(vecs[i].sec, vecs[i].idx, vecs[i].data, 1'b1);
      wait_commit(n);
      check($sformatf("vec%0d_latency", i), 32'(n), 32'd2);
      check($sformatf("vec%0d_coef", i), 32'(coef(vecs[i].chk_sec, vecs[i].chk_idx)),
            32'(vecs[i].exp));
      check($sformatf("vec%0d_error", i), 32'(cfg_error), 32'd0);
      tick();
      check($sformatf("vec%0d_pulse_end", i), 32'(cfg_commit_done), 32'd0);
    end
    check("s0_a1_other_fields", 32'(cr_a1[0]), 32'h000001);
    check("s2_a1_signed", 32'(cr_a1[2]), 32'h800000);

    // Multi-write bank: live untouched until the last write commits.
    cfg_write(0, 0, 24'h0000AA, 1'b0);
    cfg_write(0, 1, 24'h0000BB, 1'b0);
    check("load_live_a1_held", 32'(cr_a1[0]), 32'h000001);
    check("load_x_ready", 32'(x_ready), 32'd1);
    cfg_write(0, 2, 24'h0C0000, 1'b1);
    wait_commit(n);
    check("bank_latency", 32'(n), 32'd2);
    check("bank_a1", 32'(cr_a1[0]), 32'h0000AA);
    check("bank_a2", 32'(cr_a2[0]), 32'h0000BB);
    check("bank_k", 32'(cr_gain_k[0]), 32'h0C0000);
    tick();

    // Five samples in flight hold the commit until the fifth output.
    x_valid_in = 1'b1;
    x_in       = 24'h000777;
    #1;
    check("x_out_pass", 32'(x_out), 32'h000777);
    repeat (5) tick();
    x_valid_in = 1'b0;
    cfg_write(0, 0, 24'h000111, 1'b1);
    check("drain_x_ready", 32'(x_ready), 32'd0);
    check("drain_cfg_ready", 32'(cfg_ready), 32'd0);
    x_valid_in = 1'b1;
    #1;
    check("drain_x_valid_out", 32'(x_valid_out), 32'd0);
    x_valid_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      y_valid_in = 1'b1;
      tick();
      y_valid_in = 1'b0;
      check($sformatf("drain_wait%0d_commit", i), 32'(cfg_commit_done), 32'd0);
      check($sformatf("drain_wait%0d_x_ready", i), 32'(x_ready), 32'd0);
    end
    tick();
    check("drain_commit", 32'(cfg_commit_done), 32'd1);
    check("drain_a1", 32'(cr_a1[0]), 32'h000111);
    tick();
    check("drain_done_x_ready", 32'(x_ready), 32'd1);
    check("drain_done_pulse", 32'(cfg_commit_done), 32'd0);

    // Entry and exit in the same cycle leave the in-flight count at one.
    x_valid_in = 1'b1;
    tick();
    x_valid_in = 1'b1;
    y_valid_in = 1'b1;
    cfg_write(2, 1, 24'h000222, 1'b1);
    x_valid_in = 1'b0;
    y_valid_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("both_wait%0d", i), 32'(cfg_commit_done), 32'd0);
      tick();
    end
    y_valid_in = 1'b1;
    tick();
    y_valid_in = 1'b0;
    check("both_last_drain", 32'(cfg_commit_done), 32'd0);
    tick();
    check("both_commit", 32'(cfg_commit_done), 32'd1);
    check("both_a2", 32'(cr_a2[2]), 32'h000222);
    check("both_error", 32'(cfg_error), 32'd0);
    tick();

    // Illegal index: accepted, bank untouched, sticky error until reset.
    do_reset();
    cfg_write(1, 3, 24'hABCDEF, 1'b1);
    wait_commit(n);
    check("idx3_error", 32'(cfg_error), 32'd1);
    check("idx3_a1", 32'(cr_a1[1]), 32'd0);
    check("idx3_a2", 32'(cr_a2[1]), 32'd0);
    check("idx3_k", 32'(cr_gain_k[1]), 32'(UNITY));
    repeat (3) tick();
    check("idx3_sticky", 32'(cfg_error), 32'd1);
    do_reset();
    check("idx3_rst_clears", 32'(cfg_error), 32'd0);

    // Out-of-range section.
    cfg_write(3, 0, 24'h123456, 1'b1);
    wait_commit(n);
    check("sec3_latency", 32'(n), 32'd2);
    check("sec3_error", 32'(cfg_error), 32'd1);
    check("sec3_s0_a1", 32'(cr_a1[0]), 32'd0);
    check("sec3_s2_a1", 32'(cr_a1[2]), 32'd0);
    tick();

    // Output with nothing in flight.
    do_reset();
    y_valid_in = 1'b1;
    tick();
    y_valid_in = 1'b0;
    check("underflow_error", 32'(cfg_error), 32'd1);
    cfg_write(0, 1, 24'h000003, 1'b1);
    wait_commit(n);
    check("underflow_no_wrap", 32'(n), 32'd2);
    tick();

    // Reset mid-LOAD discards the pending bank.
    do_reset();
    cfg_write(0, 0, 24'h00AAAA, 1'b0);
    do_reset();
    check("midload_live_a1", 32'(cr_a1[0]), 32'd0);
    check("midload_cfg_ready", 32'(cfg_ready), 32'd1);
    cfg_write(0, 1, 24'h000005, 1'b1);
    wait_commit(n);
    check("midload_shadow_a1", 32'(cr_a1[0]), 32'd0);
    check("midload_a2", 32'(cr_a2[0]), 32'h000005);
    tick();

    // Reset mid-DRAIN: live returns to pass-through.
    x_valid_in = 1'b1;
    tick();
    x_valid_in = 1'b0;
    cfg_write(1, 2, 24'h040000, 1'b1);
    repeat (3) tick();
    do_reset();
    check("middrain_k", 32'(cr_gain_k[1]), 32'(UNITY));
    check("middrain_a2", 32'(cr_a2[0]), 32'd0);
    check("middrain_x_ready", 32'(x_ready), 32'd1);

`ifdef IIR_CFG_DRAIN_TIMEOUT_EN
    do_reset();
    x_valid_in = 1'b1;
    tick();
    x_valid_in = 1'b0;
    cfg_write(2, 0, 24'h000333, 1'b1);
    wait_commit(n);
    check("timeout_cycle", 32'(n), 32'd17);
    check("timeout_error", 32'(cfg_error), 32'd1);
    check("timeout_a1", 32'(cr_a1[2]), 32'h000333);
    tick();
    cfg_write(2, 1, 24'h000444, 1'b1);
    wait_commit(n);
    check("timeout_inflight_cleared", 32'(n), 32'd2);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
